// File: rtl/nn_pkg.sv
// nn_pkg
//   Shared definitions for the NN weight-load path.
//   - state_t    : weight-load sequencer FSM encoding
//   - idx_w()    : index width for a count of items (never less than 1 bit)
//   - NN_UNIT_W / NN_WADDR_W : index widths for the default 4x4 unit array
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SUM   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NN_UNIT_W  = idx_w(4);
  localparam int NN_WADDR_W = idx_w(4);

endpackage

// File: rtl/nn_tag_pipe.sv
// nn_tag_pipe
//   DEPTH-deep shift register of {valid, unit, slot}. Models the weight RAM
//   read latency: a tag pushed in cycle t appears on the outputs in t+DEPTH,
//   which is exactly when the RAM data for that read is valid.
//   Unit/slot of a stage only load when a valid tag moves in, so the output
//   stage keeps the last delivered tag while o_valid is low.
// Ports
//   i_clk, i_reset : clock, synchronous active-high reset (flushes the pipe)
//   i_valid        : a read was issued this cycle
//   i_unit, i_slot : target unit / weight slot of that read
//   o_valid        : tag at the output stage is live (unit write strobe)
//   o_unit, o_slot : target of the current / most recent write
//   o_empty        : nothing in flight behind the output stage
module nn_tag_pipe #(
  parameter int DEPTH   = 2,
  parameter int UNIT_W  = 2,
  parameter int WADDR_W = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [UNIT_W-1:0]  i_unit,
  input  logic [WADDR_W-1:0] i_slot,
  output logic               o_valid,
  output logic [UNIT_W-1:0]  o_unit,
  output logic [WADDR_W-1:0] o_slot,
  output logic               o_empty
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH*UNIT_W-1:0]  r_unit;
  logic [DEPTH*WADDR_W-1:0] r_slot;

  // Chain element k feeds stage k; element DEPTH is the output stage.
  logic [DEPTH:0]               w_valid_chain;
  logic [(DEPTH+1)*UNIT_W-1:0]  w_unit_chain;
  logic [(DEPTH+1)*WADDR_W-1:0] w_slot_chain;

  assign w_valid_chain = {r_valid, i_valid};
  assign w_unit_chain  = {r_unit, i_unit};
  assign w_slot_chain  = {r_slot, i_slot};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_unit  <= '0;
      r_slot  <= '0;
    end else begin
      r_valid <= w_valid_chain[DEPTH-1:0];
      for (int k = 0; k < DEPTH; k++) begin
        if (w_valid_chain[k]) begin
          r_unit[k*UNIT_W +: UNIT_W]   <= w_unit_chain[k*UNIT_W +: UNIT_W];
          r_slot[k*WADDR_W +: WADDR_W] <= w_slot_chain[k*WADDR_W +: WADDR_W];
        end
      end
    end
  end

  assign o_valid = w_valid_chain[DEPTH];
  assign o_unit  = w_unit_chain[DEPTH*UNIT_W +: UNIT_W];
  assign o_slot  = w_slot_chain[DEPTH*WADDR_W +: WADDR_W];

  // Looking only behind the output stage lets the controller leave DRAIN in
  // the same cycle the final write is presented, not one cycle later.
  if (DEPTH == 1) begin : g_empty_d1
    assign o_empty = 1'b1;
  end else begin : g_empty_dn
    assign o_empty = ~|r_valid[DEPTH-2:0];
  end

endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer
//   Streams one layer's weights from the weight RAM into NUM_UNITS neuron
//   units, WEIGHTS_PER_UNIT each. One RAM read per cycle; each read's target
//   is carried through a RAM_LATENCY tag pipe so writes land back-to-back with
//   no per-word stalls. Pulses sum_trigger after the last write, then done.
//
//   state  | meaning
//   IDLE   | waiting for start; invalid layer pulses error
//   ISSUE  | one RAM read per cycle, N*M reads
//   DRAIN  | reads finished, waiting for tags still in flight
//   SUM    | sum_trigger pulse
//   DONE   | done pulse, busy drops next cycle
//
// Ports
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_start, i_layer   : load request and layer index (sampled in IDLE only)
//   o_ram_addr         : weight RAM read address
//   o_ram_rd_en        : read strobe, one per issued address
//   o_unit_sel         : target unit of current write
//   o_unit_address     : weight slot within the unit
//   o_write            : unit write strobe (RAM data valid)
//   o_sum_trigger      : one-cycle pulse after the last write
//   o_busy             : load in progress (cycle after start through DONE)
//   o_done             : one-cycle completion pulse
//   o_error            : one-cycle pulse for an out-of-range layer
module weight_load_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_UNITS        = 4,
  parameter int WEIGHTS_PER_UNIT = 4,
  parameter int ADDR_W           = 10,
  parameter int NUM_LAYERS       = 3,
  parameter int LAYER_W          = 2,
  parameter int LAYER_STRIDE     = 16,
  parameter int RAM_LATENCY      = 2,
  localparam int UNIT_W          = idx_w(NUM_UNITS),
  localparam int WADDR_W         = idx_w(WEIGHTS_PER_UNIT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [LAYER_W-1:0] i_layer,
  output logic [ADDR_W-1:0]  o_ram_addr,
  output logic               o_ram_rd_en,
  output logic [UNIT_W-1:0]  o_unit_sel,
  output logic [WADDR_W-1:0] o_unit_address,
  output logic               o_write,
  output logic               o_sum_trigger,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam int TOTAL = NUM_UNITS * WEIGHTS_PER_UNIT;
  localparam int CNT_W = idx_w(TOTAL);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [WADDR_W-1:0] SLOT_LAST = WADDR_W'(WEIGHTS_PER_UNIT - 1);
  localparam logic [ADDR_W-1:0]  STRIDE    = ADDR_W'(LAYER_STRIDE);

  if ((NUM_UNITS < 2) || (WEIGHTS_PER_UNIT < 2) || (RAM_LATENCY < 1)) begin : g_bad_shape
    $error("weight_load_sequencer: NUM_UNITS/WEIGHTS_PER_UNIT must be >= 2, RAM_LATENCY >= 1");
  end
  if ((NUM_LAYERS * LAYER_STRIDE > (1 << ADDR_W)) || (LAYER_STRIDE < TOTAL)) begin : g_bad_map
    $error("weight_load_sequencer: layer map exceeds RAM or LAYER_STRIDE < units*weights");
  end

  state_t             r_state;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic               r_ram_rd_en;
  logic [UNIT_W-1:0]  r_unit_cnt;
  logic [WADDR_W-1:0] r_slot_cnt;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic               r_sum_trigger;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic               w_layer_ok;
  logic [ADDR_W-1:0]  w_base;
  logic               w_pipe_empty;

  assign w_layer_ok = (int'(i_layer) < NUM_LAYERS);
  // Address arithmetic is ADDR_W wide; any carry out is dropped.
  assign w_base     = ADDR_W'(i_layer) * STRIDE;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_ram_addr    <= '0;
      r_ram_rd_en   <= 1'b0;
      r_unit_cnt    <= '0;
      r_slot_cnt    <= '0;
      r_issue_cnt   <= '0;
      r_sum_trigger <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_sum_trigger <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_layer_ok) begin
              r_state     <= ST_ISSUE;
              r_ram_addr  <= w_base;
              r_ram_rd_en <= 1'b1;
              r_unit_cnt  <= '0;
              r_slot_cnt  <= '0;
              r_issue_cnt <= CNT_LAST;
              r_busy      <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          // r_issue_cnt counts reads remaining after the one on the bus now.
          if (r_issue_cnt == '0) begin
            r_ram_rd_en <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            r_issue_cnt <= r_issue_cnt - 1'b1;
            r_ram_addr  <= r_ram_addr + 1'b1;
            if (r_slot_cnt == SLOT_LAST) begin
              r_slot_cnt <= '0;
              r_unit_cnt <= r_unit_cnt + 1'b1;
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // Leaves while the final write is on the output stage, so
          // sum_trigger follows the last write directly.
          if (w_pipe_empty) begin
            r_state       <= ST_SUM;
            r_sum_trigger <= 1'b1;
          end
        end

        ST_SUM: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  nn_tag_pipe #(
    .DEPTH   (RAM_LATENCY),
    .UNIT_W  (UNIT_W),
    .WADDR_W (WADDR_W)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (r_ram_rd_en),
    .i_unit  (r_unit_cnt),
    .i_slot  (r_slot_cnt),
    .o_valid (o_write),
    .o_unit  (o_unit_sel),
    .o_slot  (o_unit_address),
    .o_empty (w_pipe_empty)
  );

  assign o_ram_addr    = r_ram_addr;
  assign o_ram_rd_en   = r_ram_rd_en;
  assign o_sum_trigger = r_sum_trigger;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_weight_load_sequencer.sv
module tb_weight_load_sequencer;

  typedef struct {
    int dut;        // 0: defaults, 1: L=1, 2: L=3, 3: 8 units x 2 weights
    int layer;
    int xs1;        // extra start pulse cycles (-1 = none)
    int xs2;
    int xs_layer;
    int err_cyc;    // expected cycles (relative to start at 0), -1 = never
    int base;
    int reads;
    int w_first;
    int w_last;
    int nwrite;
    int sum_last;
    int done_last;
    int busy_first;
    int busy_last;
    int busy_cnt;
    int loads;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start;
  logic [1:0] layer;

  always #5 clk = ~clk;

  logic [9:0] a  [4];
  logic       rd [4];
  logic       wr [4];
  logic       sm [4];
  logic       dn [4];
  logic       bs [4];
  logic       er [4];
  logic [1:0] us0, us1, us2, ua0, ua1, ua2;
  logic [2:0] us3;
  logic [0:0] ua3;
  logic [2:0] m_unit [4];
  logic [1:0] m_slot [4];

  assign m_unit[0] = {1'b0, us0};
  assign m_unit[1] = {1'b0, us1};
  assign m_unit[2] = {1'b0, us2};
  assign m_unit[3] = us3;
  assign m_slot[0] = ua0;
  assign m_slot[1] = ua1;
  assign m_slot[2] = ua2;
  assign m_slot[3] = {1'b0, ua3};

  weight_load_sequencer u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(start[0]), .i_layer(layer),
    .o_ram_addr(a[0]), .o_ram_rd_en(rd[0]), .o_unit_sel(us0), .o_unit_address(ua0),
    .o_write(wr[0]), .o_sum_trigger(sm[0]), .o_busy(bs[0]), .o_done(dn[0]), .o_error(er[0]));

  weight_load_sequencer #(.RAM_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start[1]), .i_layer(layer),
    .o_ram_addr(a[1]), .o_ram_rd_en(rd[1]), .o_unit_sel(us1), .o_unit_address(ua1),
    .o_write(wr[1]), .o_sum_trigger(sm[1]), .o_busy(bs[1]), .o_done(dn[1]), .o_error(er[1]));

  weight_load_sequencer #(.RAM_LATENCY(3)) u_dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start[2]), .i_layer(layer),
    .o_ram_addr(a[2]), .o_ram_rd_en(rd[2]), .o_unit_sel(us2), .o_unit_address(ua2),
    .o_write(wr[2]), .o_sum_trigger(sm[2]), .o_busy(bs[2]), .o_done(dn[2]), .o_error(er[2]));

  weight_load_sequencer #(.NUM_UNITS(8), .WEIGHTS_PER_UNIT(2), .LAYER_STRIDE(16)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start[3]), .i_layer(layer),
    .o_ram_addr(a[3]), .o_ram_rd_en(rd[3]), .o_unit_sel(us3), .o_unit_address(ua3),
    .o_write(wr[3]), .o_sum_trigger(sm[3]), .o_busy(bs[3]), .o_done(dn[3]), .o_error(er[3]));

  int total = 0;
  int bad   = 0;

  function automatic int m_of(input int d);
    return (d == 3) ? 2 : 4;
  endfunction

  function automatic int n_of(input int d);
    return (d == 3) ? 8 : 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm, input int d);
    chk(nm, int'({a[d], rd[d], m_unit[d], m_slot[d], wr[d], sm[d], dn[d], bs[d], er[d]}), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d;
    int first_addr, reads, w_first, w_last, nw, sum_last, nsum;
    int done_last, ndone, busy_first, busy_last, nbusy, err_cyc, nerr;
    int addr_bad, tag_bad, k;
    d = v.dut;
    first_addr = -1; reads = 0; w_first = -1; w_last = -1; nw = 0;
    sum_last = -1; nsum = 0; done_last = -1; ndone = 0;
    busy_first = -1; busy_last = -1; nbusy = 0; err_cyc = -1; nerr = 0;
    addr_bad = 0; tag_bad = 0;

    @(negedge clk);
    layer    = v.layer[1:0];
    start[d] = 1'b1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (rd[d]) begin
        if (first_addr < 0) first_addr = int'(a[d]);
        if (int'(a[d]) != v.base + (reads % 16)) addr_bad++;
        reads++;
      end
      if (wr[d]) begin
        if (w_first < 0) w_first = cyc;
        w_last = cyc;
        k = nw % 16;
        if (int'(m_unit[d]) != k / m_of(d) || int'(m_slot[d]) != k % m_of(d)) tag_bad++;
        nw++;
      end
      if (sm[d]) begin sum_last = cyc; nsum++; end
      if (dn[d]) begin done_last = cyc; ndone++; end
      if (bs[d]) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        nbusy++;
      end
      if (er[d]) begin err_cyc = cyc; nerr++; end
      start[d] = (cyc == v.xs1 || cyc == v.xs2);
      layer    = start[d] ? v.xs_layer[1:0] : 2'd3;
    end
    start[d] = 1'b0;

    chk($sformatf("%s.err_cyc", tag),    err_cyc,    v.err_cyc);
    chk($sformatf("%s.err_cnt", tag),    nerr,       (v.err_cyc >= 0) ? 1 : 0);
    chk($sformatf("%s.base", tag),       first_addr, v.base);
    chk($sformatf("%s.reads", tag),      reads,      v.reads);
    chk($sformatf("%s.addr_seq", tag),   addr_bad,   0);
    chk($sformatf("%s.w_first", tag),    w_first,    v.w_first);
    chk($sformatf("%s.w_last", tag),     w_last,     v.w_last);
    chk($sformatf("%s.nwrite", tag),     nw,         v.nwrite);
    chk($sformatf("%s.unit_slot", tag),  tag_bad,    0);
    chk($sformatf("%s.sum_cyc", tag),    sum_last,   v.sum_last);
    chk($sformatf("%s.sum_cnt", tag),    nsum,       v.loads);
    chk($sformatf("%s.done_cyc", tag),   done_last,  v.done_last);
    chk($sformatf("%s.done_cnt", tag),   ndone,      v.loads);
    chk($sformatf("%s.busy_first", tag), busy_first, v.busy_first);
    chk($sformatf("%s.busy_last", tag),  busy_last,  v.busy_last);
    chk($sformatf("%s.busy_cnt", tag),   nbusy,      v.busy_cnt);
    if (v.loads > 0) begin
      chk($sformatf("%s.hold_unit", tag), int'(m_unit[d]), n_of(d) - 1);
      chk($sformatf("%s.hold_slot", tag), int'(m_slot[d]), m_of(d) - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    int   nw_pre, quiet;

    //         dut lay xs1 xs2 xsl err base rds wf  wl  nw sum dn bf bl  bc ld
    vt[0]  = '{0,  1,  -1, -1, 0,  -1, 16,  16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[1]  = '{0,  2,  -1, -1, 0,  -1, 32,  16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[2]  = '{0,  3,  -1, -1, 0,  1,  -1,  0,  -1, -1, 0,  -1, -1, -1, -1, 0, 0};
    vt[3]  = '{0,  1,  5,  20, 3,  -1, 16,  16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[4]  = '{0,  0,  -1, -1, 0,  -1, 0,   16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[5]  = '{1,  1,  -1, -1, 0,  -1, 16,  16, 2,  17, 16, 18, 19, 1, 19, 19, 1};
    vt[6]  = '{2,  1,  -1, -1, 0,  -1, 16,  16, 4,  19, 16, 20, 21, 1, 21, 21, 1};
    vt[7]  = '{3,  1,  -1, -1, 0,  -1, 16,  16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[8]  = '{3,  2,  -1, -1, 0,  -1, 32,  16, 3,  18, 16, 19, 20, 1, 20, 20, 1};
    vt[9]  = '{0,  0,  21, -1, 0,  -1, 0,   32, 3,  39, 32, 40, 41, 1, 41, 40, 2};
    vt[10] = '{1,  3,  -1, -1, 0,  1,  -1,  0,  -1, -1, 0,  -1, -1, -1, -1, 0, 0};

    reset = 1'b1;
    start = '0;
    layer = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) chk_quiet($sformatf("reset_state.dut%0d", d), d);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a load, then a fresh load at cycle 12.
    nw_pre = 0;
    quiet  = 0;
    @(negedge clk);
    layer    = 2'd1;
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
      layer    = 2'd3;
      if (wr[0]) nw_pre++;
      if (cyc == 8) reset = 1'b1;
    end
    chk("midreset.pre_writes", nw_pre, 6);
    @(negedge clk);
    reset = 1'b0;
    chk_quiet("midreset.outs_cyc9", 0);
    for (int cyc = 10; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (wr[0] || rd[0] || bs[0]) quiet++;
    end
    chk("midreset.quiet_10_11", quiet, 0);
    run_vec(vt[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
